// File: rtl/nco_multi.sv
// nco_multi: time-multiplexed multi-channel numerically controlled oscillator.
//   CHANNELS phase accumulators share one 3-stage waveform pipeline. Once per
//   sample period (DIV = CLK_FREQ/SAMPLE_RATE clocks) every channel emits one
//   sample, in channel order, as a strobed stream.
// Ports:
//   clk, reset   - system clock, synchronous active-high reset
//   cfg_we       - write strobe for the shadow config of channel cfg_ch
//   cfg_inc      - phase increment per sample
//   cfg_wave     - 0 sine, 1 triangle, 2 sawtooth, 3 square
//   cfg_duty     - square-wave threshold
//   cfg_offset   - phase offset added to the accumulator phase
//   sync         - clears all accumulators and aborts the frame in flight
//   out_data     - sample value, held between strobes
//   out_ch       - channel of out_data
//   out_valid    - one-cycle strobe per sample
//   frame_done   - pulses together with the last channel's out_valid
module nco_multi #(
  parameter int CLK_FREQ    = 50_000_000,
  parameter int SAMPLE_RATE = 48_000,
  parameter int BIT_DEPTH   = 16,
  parameter int CHANNELS    = 4,
  parameter int ACC_WIDTH   = 32,
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cfg_we,
  input  logic [CW-1:0]        cfg_ch,
  input  logic [ACC_WIDTH-1:0] cfg_inc,
  input  logic [1:0]           cfg_wave,
  input  logic [BIT_DEPTH-1:0] cfg_duty,
  input  logic [BIT_DEPTH-1:0] cfg_offset,
  input  logic                 sync,
  output logic [BIT_DEPTH-1:0] out_data,
  output logic [CW-1:0]        out_ch,
  output logic                 out_valid,
  output logic                 frame_done
);

  localparam int B     = BIT_DEPTH;
  localparam int DIV   = CLK_FREQ / SAMPLE_RATE;
  localparam int CNT_W = $clog2(DIV);
  localparam logic [B-1:0] HALF = {1'b1, {(B-1){1'b0}}};
  localparam logic [B-1:0] MAX  = '1;

  if (DIV < CHANNELS + 4) begin : g_div_chk
    $error("nco_multi: CLK_FREQ/SAMPLE_RATE must be >= CHANNELS+4");
  end

  typedef enum logic {IDLE, RUN} state_t;

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic                 tick;
  logic                 last_p0;
  logic [CW-1:0]        ch_p0;
  logic [B-1:0]         phase_p0;

  logic [ACC_WIDTH-1:0] acc     [CHANNELS];
  logic [ACC_WIDTH-1:0] sh_inc  [CHANNELS];
  logic [1:0]           sh_wave [CHANNELS];
  logic [B-1:0]         sh_duty [CHANNELS];
  logic [B-1:0]         sh_off  [CHANNELS];
  logic [ACC_WIDTH-1:0] lv_inc  [CHANNELS];
  logic [1:0]           lv_wave [CHANNELS];
  logic [B-1:0]         lv_duty [CHANNELS];
  logic [B-1:0]         lv_off  [CHANNELS];

  logic                 vld_p1, vld_p2, last_p1, last_p2;
  logic [CW-1:0]        ch_p1, ch_p2;
  logic [B-1:0]         p_p1, duty_p1, samp_p2;
  logic [1:0]           wave_p1;

  // Sine upper half saturates at MAX.
  function automatic logic [B-1:0] sat_hi(input logic [B:0] v);
    return v[B] ? MAX : v[B-1:0];
  endfunction

  // Sine lower half floors at 0.
  function automatic logic [B-1:0] floor_lo(input logic [B:0] a);
    return (a > {1'b0, HALF}) ? '0 : (HALF - a[B-1:0]);
  endfunction

  function automatic logic [B-1:0] sine_wave(input logic [B-1:0] p);
    logic [2*B-3:0] qx, hx, prod, ash;
    logic [B:0]     a;
    qx   = (2*B-2)'(p[B-2:0]);
    hx   = (2*B-2)'(HALF) - qx;
    prod = qx * hx;
    ash  = prod >> (B-3);
    a    = ash[B:0];
    return p[B-1] ? floor_lo(a) : sat_hi({1'b0, HALF} + a);
  endfunction

  function automatic logic [B-1:0] waveform(input logic [B-1:0] p,
                                            input logic [1:0]   w,
                                            input logic [B-1:0] duty);
    logic [B-1:0] tri2;
    tri2 = {p[B-2:0], 1'b0};
    case (w)
      2'd0:    return sine_wave(p);
      2'd1:    return p[B-1] ? (MAX - tri2) : tri2;
      2'd2:    return p;
      default: return (p < duty) ? MAX : '0;
    endcase
  endfunction

  assign tick     = (cnt == CNT_W'(DIV - 1));
  assign last_p0  = (ch_p0 == CW'(CHANNELS - 1));
  assign phase_p0 = acc[ch_p0][ACC_WIDTH-1 -: B] + lv_off[ch_p0];

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= '0;
      state      <= IDLE;
      ch_p0      <= '0;
      vld_p1     <= 1'b0;
      vld_p2     <= 1'b0;
      last_p1    <= 1'b0;
      last_p2    <= 1'b0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      out_data   <= HALF;
      out_ch     <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        acc[i]     <= '0;
        sh_inc[i]  <= '0;
        sh_wave[i] <= 2'd0;
        sh_duty[i] <= HALF;
        sh_off[i]  <= '0;
        lv_inc[i]  <= '0;
        lv_wave[i] <= 2'd0;
        lv_duty[i] <= HALF;
        lv_off[i]  <= '0;
      end
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;

      if (tick) begin
        for (int i = 0; i < CHANNELS; i++) begin
          lv_inc[i]  <= sh_inc[i];
          lv_wave[i] <= sh_wave[i];
          lv_duty[i] <= sh_duty[i];
          lv_off[i]  <= sh_off[i];
        end
      end

      if (cfg_we && (int'(cfg_ch) < CHANNELS)) begin
        sh_inc[cfg_ch]  <= cfg_inc;
        sh_wave[cfg_ch] <= cfg_wave;
        sh_duty[cfg_ch] <= cfg_duty;
        sh_off[cfg_ch]  <= cfg_offset;
      end

      // S0 -> S1: issue one channel per RUN cycle
      vld_p1  <= (state == RUN);
      last_p1 <= (state == RUN) && last_p0;
      // S1 -> S2
      vld_p2  <= vld_p1;
      last_p2 <= last_p1;
      // S2 -> S3
      out_valid  <= vld_p2;
      frame_done <= last_p2;
      if (vld_p2 && !sync) begin
        out_data <= samp_p2;
        out_ch   <= ch_p2;
      end

      case (state)
        IDLE: begin
          if (tick) begin
            state <= RUN;
            ch_p0 <= '0;
          end
        end
        RUN: begin
          acc[ch_p0] <= acc[ch_p0] + lv_inc[ch_p0];
          if (last_p0) state <= IDLE;
          else         ch_p0 <= ch_p0 + 1'b1;
        end
        default: state <= IDLE;
      endcase

      if (sync) begin
        state      <= IDLE;
        ch_p0      <= '0;
        vld_p1     <= 1'b0;
        vld_p2     <= 1'b0;
        last_p1    <= 1'b0;
        last_p2    <= 1'b0;
        out_valid  <= 1'b0;
        frame_done <= 1'b0;
        for (int i = 0; i < CHANNELS; i++) acc[i] <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    // S0 -> S1: phase capture
    ch_p1   <= ch_p0;
    p_p1    <= phase_p0;
    wave_p1 <= lv_wave[ch_p0];
    duty_p1 <= lv_duty[ch_p0];
    // S1 -> S2: waveform
    ch_p2   <= ch_p1;
    samp_p2 <= waveform(p_p1, wave_p1, duty_p1);
  end

endmodule

// File: tb/tb_nco_multi.sv
module tb_nco_multi;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_ch = '0;
  logic [31:0] cfg_inc = '0;
  logic [1:0]  cfg_wave = '0;
  logic [15:0] cfg_duty = '0;
  logic [15:0] cfg_offset = '0;
  logic        sync = 1'b0;
  logic [15:0] out_data;
  logic [1:0]  out_ch;
  logic        out_valid;
  logic        frame_done;

  nco_multi #(
    .CLK_FREQ(1_000_000), .SAMPLE_RATE(100_000), .BIT_DEPTH(16),
    .CHANNELS(4), .ACC_WIDTH(32)
  ) dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_inc(cfg_inc), .cfg_wave(cfg_wave), .cfg_duty(cfg_duty),
    .cfg_offset(cfg_offset), .sync(sync), .out_data(out_data),
    .out_ch(out_ch), .out_valid(out_valid), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  ch;
    logic [15:0] data;
    logic        fd;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   fails  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_frame(input logic [15:0] d0, input logic [15:0] d1,
                            input logic [15:0] d2, input logic [15:0] d3);
    logic [15:0] d [4];
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    for (int k = 0; k < 4; k++) begin
      exp_t e;
      e.ch   = 2'(k);
      e.data = d[k];
      e.fd   = (k == 3);
      q.push_back(e);
    end
  endtask

  task automatic cfg(input logic [1:0] ch, input logic [31:0] inc, input logic [1:0] wave,
                     input logic [15:0] duty, input logic [15:0] off);
    cfg_we = 1'b1; cfg_ch = ch; cfg_inc = inc; cfg_wave = wave;
    cfg_duty = duty; cfg_offset = off;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic wait_ch0();
    bit found;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1 && out_ch === 2'd0) found = 1'b1;
    end
    if (!found) begin
      fails++;
      checks++;
      $display("FAIL frame_timeout: no ch0 strobe within 40 cycles, expected one");
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
    end
  endtask

  // Scoreboard monitor: every strobe must match the oldest expected sample.
  initial begin
    forever begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        if (q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_strobe: got ch %0d data %h, expected no strobe", out_ch, out_data);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk($sformatf("ch%0d_data", e.ch), 32'(out_data), 32'(e.data));
          chk("out_ch", 32'(out_ch), 32'(e.ch));
          chk($sformatf("ch%0d_frame_done", e.ch), 32'(frame_done), 32'(e.fd));
        end
      end
    end
  end

  initial begin
    logic [15:0] d0, d1, d2, d3;
    repeat (5) @(negedge clk);
    chk("reset_valid", 32'(out_valid), 32'd0);
    chk("reset_data", 32'(out_data), 32'h8000);
    chk("reset_ch", 32'(out_ch), 32'd0);
    chk("reset_frame_done", 32'(frame_done), 32'd0);
    push_frame(16'h8000, 16'h8000, 16'h8000, 16'h8000);
    reset = 1'b0;

    for (int n = 0; n <= 20; n++) begin
      wait_ch0();
      case (n)
        0: begin
          cfg(2'd0, 32'h1000_0000, 2'd2, 16'h8000, 16'h0000);
          cfg(2'd1, 32'h0,         2'd0, 16'h8000, 16'h4000);
          cfg(2'd2, 32'h2000_0000, 2'd3, 16'h4000, 16'h0000);
          cfg(2'd3, 32'h0,         2'd1, 16'h8000, 16'h4000);
        end
        1: begin
          cfg(2'd1, 32'h0, 2'd0, 16'h8000, 16'hC000);
          cfg(2'd3, 32'h0, 2'd1, 16'h8000, 16'hC000);
        end
        2: cfg(2'd1, 32'h0, 2'd0, 16'h8000, 16'h2000);
        3: cfg(2'd1, 32'h0, 2'd0, 16'h8000, 16'h0000);
        default: ;
      endcase

      if (n <= 18) begin
        d0 = 16'((n) * 32'h1000);
        case (n + 1)
          1: d1 = 16'hFFFF;
          2: d1 = 16'h0000;
          3: d1 = 16'hE000;
          default: d1 = 16'h8000;
        endcase
        d2 = ((n % 8) < 2) ? 16'hFFFF : 16'h0000;
        d3 = (n + 1 == 1 || n + 1 == 19) ? 16'h8000 : 16'h7FFF;
        push_frame(d0, d1, d2, d3);
      end

      if (n == 17) begin
        // Write lands in the RUN phase of the next frame.
        repeat (8) @(negedge clk);
        cfg(2'd3, 32'h0, 2'd1, 16'h8000, 16'h4000);
      end

      if (n == 19) begin
        // Sync on the tick cycle: that frame is dropped, phases restart.
        repeat (6) @(negedge clk);
        sync = 1'b1;
        @(negedge clk);
        sync = 1'b0;
        push_frame(16'h0000, 16'h8000, 16'hFFFF, 16'h8000);
      end

      if (n == 20) begin
        repeat (8) @(negedge clk);
        reset = 1'b1;
        repeat (3) begin
          @(negedge clk);
          chk("midframe_reset_valid", 32'(out_valid), 32'd0);
          chk("midframe_reset_data", 32'(out_data), 32'h8000);
        end
        reset = 1'b0;
        repeat (8) begin
          @(negedge clk);
          chk("post_reset_valid", 32'(out_valid), 32'd0);
        end
      end
    end

    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/nco_multi.md
Name: nco_multi

Overview:
- Time-multiplexed multi-channel numerically controlled oscillator; next generation of the single-channel NCO.
- CHANNELS independent phase accumulators share one 3-stage waveform pipeline.
- Once per sample period the block emits one sample per channel as a strobed stream, for the mixer/DAC stage.
- Per channel: phase increment, waveform (sine/triangle/sawtooth/square), duty cycle and phase offset; global phase sync.

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz.
- SAMPLE_RATE, 48_000, output frame rate in Hz. DIV = CLK_FREQ/SAMPLE_RATE must be >= CHANNELS+4 (elaboration-time check).
- BIT_DEPTH, 16, sample width B. Also the width of phase, duty and offset.
- CHANNELS, 4, number of oscillators, >= 1. CW = max(1, clog2(CHANNELS)).
- ACC_WIDTH, 32, phase accumulator width, >= BIT_DEPTH.

Ports:
- clk  in  1  system clock.
- reset  in  1  reset.
- cfg_we  in  1  config write strobe.
- cfg_ch  in  CW  channel addressed by the write.
- cfg_inc  in  ACC_WIDTH  phase increment per sample.
- cfg_wave  in  2  0 sine, 1 triangle, 2 sawtooth, 3 square.
- cfg_duty  in  B  square threshold.
- cfg_offset  in  B  phase offset.
- sync  in  1  clears all accumulators.
- out_data  out  B  sample value.
- out_ch  out  CW  channel of out_data.
- out_valid  out  1  one-cycle strobe per sample.
- frame_done  out  1  pulses with the last channel's out_valid.

Behaviour:
- One clock, clk. reset is synchronous and active-high.
- Reset values:
  - out_data = 2^(B-1); out_ch, out_valid, frame_done = 0.
  - Accumulators and tick counter = 0; FSM in IDLE.
  - Live and shadow config per channel: inc 0, wave sine, duty 2^(B-1), offset 0.
- Reset asserted mid-frame: the frame is aborted; no out_valid on the following cycle or after.
- Tick counter: counts 0..DIV-1; tick = (count == DIV-1), then wraps to 0. The first tick occurs DIV cycles after reset release.
- Config writes:
  - cfg_we writes the shadow registers of cfg_ch. cfg_ch >= CHANNELS is ignored.
  - Shadows are copied to the live registers on the tick cycle, so a frame never sees mixed configuration.
  - A write on the tick cycle itself is applied in the next frame.
- FSM:
  - IDLE -> RUN on tick. RUN issues channels 0..CHANNELS-1, one per cycle, then returns to IDLE.
  - A tick while in RUN cannot occur, given the DIV check.
- Pipeline for channel k issued at cycle t:
  - S1: p = acc_k[ACC_WIDTH-1 -: B] + offset_k (mod 2^B); acc_k <= acc_k + inc_k (mod 2^ACC_WIDTH). The sample uses the pre-increment phase.
  - S2: waveform computation, below.
  - S3: out_data/out_ch registered; out_valid = 1 at cycle t+3.
  - With tick at cycle T, channel k appears at T+1+3+k. frame_done coincides with channel CHANNELS-1.
  - out_data holds its value between strobes.
- Waveforms (p is B bits, q = p[B-2:0], HALF = 2^(B-1), MAX = 2^B-1):
  - Sine, parabolic: a = (q*(HALF-q)) >> (B-3). p[B-1]=0 gives min(HALF+a, MAX); p[B-1]=1 gives HALF-a, floored at 0.
  - Triangle: p[B-1]=0 gives q<<1; p[B-1]=1 gives MAX-(q<<1).
  - Sawtooth: p.
  - Square: MAX if p < duty, else 0. duty = 0 gives constant 0.
- sync:
  - The cycle after sync, all accumulators are 0 and any in-flight frame is aborted; strobes already in S2/S3 are dropped.
  - A tick on the same cycle as sync is discarded. The next frame starts at the following tick with all phases = offset.
- Arithmetic: all wrap modulo width, except the sine clamp. The sine product is 2B-2 bits wide.

Test Plan (B=16, CHANNELS=4, CLK_FREQ=1_000_000, SAMPLE_RATE=100_000, DIV=10):
- Reset, no config -> out_valid 0, out_data 0x8000. First frame: 4 strobes at tick+4..+7, out_ch 0..3, all data 0x8000, frame_done with ch3.
- ch0 sawtooth, inc 0x1000_0000 -> ch0 samples 0x0000, 0x1000, ..., 0xF000, then 0x0000 (wrap).
- ch1 sine, inc 0:
  - offset 0x4000 -> 0xFFFF (clamped).
  - offset 0xC000 -> 0x0000.
  - offset 0x2000 -> 0xE000.
  - offset 0x0000 -> 0x8000.
- ch2 square, duty 0x4000, inc 0x2000_0000 -> repeating 8-frame pattern 0xFFFF, 0xFFFF, then 0x0000 x6.
- ch3 triangle, inc 0: offset 0x4000 -> 0x8000; offset 0xC000 -> 0x7FFF.
- ch3 triangle, mid-frame behaviour:
  - cfg write to ch3 mid-frame -> current frame unchanged, next frame uses the new config.
  - sync on a tick cycle -> that frame is absent; next frame ch0 sawtooth = 0x0000.
  - reset mid-frame -> no further strobes.
